// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: register-file widths and arbiter defaults (the defines.v set), plus the buffered write entry type.
`ifndef REGARB_DEFINES_SV
`define REGARB_DEFINES_SV
`define RstEnable     1'b1
`define WriteEnable   1'b1
`define ZeroWord      32'h0000_0000
`define RegBus        31:0
`define RegAddrBus    4:0
`define RegArbDepth   2
`define RegArbMaxWait 4
`endif

package regfile_wr_arbiter_pkg;
    typedef logic [`RegAddrBus] reg_addr_t;
    typedef logic [`RegBus]     reg_data_t;
    typedef struct packed {
        reg_addr_t waddr;
        reg_data_t wdata;
    } wr_entry_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: writeback sources, register-file port and decode hazard signals of the write arbiter.
interface regfile_wr_arbiter_if #(parameter int DEPTH = `RegArbDepth);
    import regfile_wr_arbiter_pkg::*;
    logic                   a_we;
    reg_addr_t              a_waddr;
    reg_data_t              a_wdata;
    logic                   b_valid;
    logic                   b_ready;
    reg_addr_t              b_waddr;
    reg_data_t              b_wdata;
    logic                   we;
    reg_addr_t              waddr;
    reg_data_t              wdata;
    reg_addr_t              qaddr1;
    reg_addr_t              qaddr2;
    logic                   qhit1;
    logic                   qhit2;
    logic                   stall_req;
    logic [$clog2(DEPTH):0] buf_count;
    modport master (
        output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, qaddr1, qaddr2,
        input  b_ready, we, waddr, wdata, qhit1, qhit2, stall_req, buf_count
    );
    modport slave (
        input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata, qaddr1, qaddr2,
        output b_ready, we, waddr, wdata, qhit1, qhit2, stall_req, buf_count
    );
endinterface

// File: rtl/regarb_fifo.sv
// regarb_fifo: synchronous FIFO of pending {waddr,wdata} writes with per-entry address/valid taps for hazard checks.
module regarb_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wr_entry_t              i_din,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output wr_entry_t              o_head,
    output reg_addr_t [DEPTH-1:0]  o_ent_addr,
    output logic [DEPTH-1:0]       o_ent_vld
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    wr_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic [DEPTH-1:0] r_vld;
    always_ff @(posedge clk or posedge rst)
        if (rst == `RstEnable) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_vld <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + AW'(1);
            if (i_pop) r_rp <= r_rp + AW'(1);
            if (i_pop) r_vld[r_rp] <= 1'b0;
            if (i_push) r_vld[r_wp] <= 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    // Payload needs no reset: the valid bits alone decide what is buffered.
    always_ff @(posedge clk)
        if (i_push) r_mem[r_wp] <= i_din;
    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign o_ent_addr[g] = r_mem[g].waddr;
    end
    assign o_full    = r_cnt == CW'(DEPTH);
    assign o_empty   = r_cnt == '0;
    assign o_count   = r_cnt;
    assign o_head    = r_mem[r_rp];
    assign o_ent_vld = r_vld;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between pipeline writeback (A, priority) and buffered long-latency results (B).
// Define REGARB_STATS_EN to add the conflict_cnt / stall_cnt statistics outputs.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH    = `RegArbDepth,
    parameter int MAX_WAIT = `RegArbMaxWait
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
`ifdef REGARB_STATS_EN
    ,
    output logic [31:0]          conflict_cnt,
    output logic [31:0]          stall_cnt
`endif
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic                   w_full, w_empty, w_push, w_pop;
    logic [$clog2(DEPTH):0] w_count;
    wr_entry_t              w_head, w_din;
    reg_addr_t [DEPTH-1:0]  w_ent_addr;
    logic [DEPTH-1:0]       w_ent_vld;
    logic [WW-1:0]          r_wait, w_wait_nxt;
    logic                   r_stall;

    // Writes to r0 complete the handshake but are never buffered.
    assign w_push = bus.b_valid && bus.b_ready && (bus.b_waddr != '0);
    assign w_pop  = !bus.a_we && !w_empty;
    assign w_din  = '{waddr: bus.b_waddr, wdata: bus.b_wdata};

    regarb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_din      (w_din),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_ent_addr (w_ent_addr),
        .o_ent_vld  (w_ent_vld)
    );

    assign w_wait_nxt = (w_pop || w_empty) ? '0 :
                        (bus.a_we && r_wait != WW'(MAX_WAIT)) ? r_wait + WW'(1) : r_wait;
    always_ff @(posedge clk or posedge rst)
        if (rst == `RstEnable) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wait  <= w_wait_nxt;
            r_stall <= w_wait_nxt == WW'(MAX_WAIT);
        end

    assign bus.b_ready   = !rst && !w_full;
    assign bus.we        = !rst && (bus.a_we || !w_empty);
    assign bus.waddr     = rst ? '0 : bus.a_we ? bus.a_waddr : w_empty ? '0 : w_head.waddr;
    assign bus.wdata     = rst ? `ZeroWord : bus.a_we ? bus.a_wdata : w_empty ? `ZeroWord : w_head.wdata;
    assign bus.stall_req = r_stall;
    assign bus.buf_count = w_count;

    always_comb begin
        bus.qhit1 = 1'b0;
        bus.qhit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.qhit1 = bus.qhit1 || (w_ent_vld[i] && w_ent_addr[i] == bus.qaddr1);
            bus.qhit2 = bus.qhit2 || (w_ent_vld[i] && w_ent_addr[i] == bus.qaddr2);
        end
        bus.qhit1 = bus.qhit1 && !rst && bus.qaddr1 != '0;
        bus.qhit2 = bus.qhit2 && !rst && bus.qaddr2 != '0;
    end

`ifdef REGARB_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst == `RstEnable) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (bus.a_we && !w_empty) conflict_cnt <= conflict_cnt + 32'd1;
            if (r_stall) stall_cnt <= stall_cnt + 32'd1;
        end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus, queue-based reference model checked every cycle, plus literal expectations.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;
    localparam int DEPTH = 2;
    localparam int MAX_WAIT = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    wr_entry_t mq[$];
    int streak = 0;
    bit mstall = 1'b0;
    int unsigned mconf = 0;
    int unsigned mstc = 0;
    int n;
    bit m_pop, m_acc;

    regfile_wr_arbiter_if #(.DEPTH(DEPTH)) bus();
`ifdef REGARB_STATS_EN
    logic [31:0] conflict_cnt, stall_cnt;
`endif

    regfile_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef REGARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic awe, input reg_addr_t aa, input reg_data_t ad,
                        input logic bv, input reg_addr_t ba, input reg_data_t bd);
        @(posedge clk);
        #1;
        bus.a_we = awe;
        bus.a_waddr = aa;
        bus.a_wdata = ad;
        bus.b_valid = bv;
        bus.b_waddr = ba;
        bus.b_wdata = bd;
        @(negedge clk);
    endtask

    // Reference model: pending B writes as a queue, plus a count of consecutive blocked cycles.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            streak = 0;
            mstall = 1'b0;
            mconf = 0;
            mstc = 0;
        end else begin
            n = mq.size();
            if (mstall) mstc++;
            if (bus.a_we && n > 0) mconf++;
            m_pop = !bus.a_we && n > 0;
            m_acc = bus.b_valid && n < DEPTH;
            if (m_pop || n == 0) streak = 0;
            else if (streak < MAX_WAIT) streak++;
            mstall = streak == MAX_WAIT;
            if (m_pop) void'(mq.pop_front());
            if (m_acc && bus.b_waddr != 0) mq.push_back('{waddr: bus.b_waddr, wdata: bus.b_wdata});
        end
    end

    initial forever begin
        logic e_we, e_rdy, e_h1, e_h2;
        reg_addr_t e_addr;
        reg_data_t e_data;
        int e_n;
        @(negedge clk);
        e_n = rst ? 0 : mq.size();
        e_we = !rst && (bus.a_we || e_n > 0);
        e_addr = rst ? '0 : bus.a_we ? bus.a_waddr : e_n > 0 ? mq[0].waddr : '0;
        e_data = rst ? '0 : bus.a_we ? bus.a_wdata : e_n > 0 ? mq[0].wdata : '0;
        e_rdy = !rst && e_n < DEPTH;
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        if (!rst)
            foreach (mq[i]) begin
                if (bus.qaddr1 != 0 && mq[i].waddr == bus.qaddr1) e_h1 = 1'b1;
                if (bus.qaddr2 != 0 && mq[i].waddr == bus.qaddr2) e_h2 = 1'b1;
            end
        check("m_we", 32'(bus.we), 32'(e_we));
        check("m_waddr", 32'(bus.waddr), 32'(e_addr));
        check("m_wdata", bus.wdata, e_data);
        check("m_b_ready", 32'(bus.b_ready), 32'(e_rdy));
        check("m_buf_count", 32'(bus.buf_count), 32'(e_n));
        check("m_qhit1", 32'(bus.qhit1), 32'(e_h1));
        check("m_qhit2", 32'(bus.qhit2), 32'(e_h2));
        check("m_stall_req", 32'(bus.stall_req), 32'(!rst && mstall));
`ifdef REGARB_STATS_EN
        check("m_conflict_cnt", conflict_cnt, rst ? 32'd0 : mconf);
        check("m_stall_cnt", stall_cnt, rst ? 32'd0 : mstc);
`endif
    end

    initial begin
        bus.a_we = 0; bus.a_waddr = 0; bus.a_wdata = 0;
        bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0;
        bus.qaddr1 = 0; bus.qaddr2 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_ready", 32'(bus.b_ready), 1);
        check("init_we", 32'(bus.we), 0);
        // B only: one-cycle latency from handshake to write
        step(0, 0, 0, 1, 5, 32'hDEADBEEF);
        check("bonly_push_we", 32'(bus.we), 0);
        step(0, 0, 0, 0, 0, 0);
        check("bonly_we", 32'(bus.we), 1);
        check("bonly_waddr", 32'(bus.waddr), 5);
        check("bonly_wdata", bus.wdata, 32'hDEADBEEF);
        check("bonly_cnt1", 32'(bus.buf_count), 1);
        step(0, 0, 0, 0, 0, 0);
        check("bonly_cnt0", 32'(bus.buf_count), 0);
        check("bonly_idle", 32'(bus.we), 0);
        // Conflict: r7 starved by six A writes
        step(0, 0, 0, 1, 7, 32'h7777_0007);
        for (int k = 1; k <= 6; k++) begin
            step(1, reg_addr_t'(k), 32'hA000_0000 + k, 0, 0, 0);
            check("conf_waddr", 32'(bus.waddr), k);
            check("conf_stall", 32'(bus.stall_req), (k >= 5) ? 1 : 0);
        end
        step(0, 0, 0, 0, 0, 0);
        check("conf_r7_waddr", 32'(bus.waddr), 7);
        check("conf_r7_wdata", bus.wdata, 32'h7777_0007);
        check("conf_stall_held", 32'(bus.stall_req), 1);
        step(0, 0, 0, 0, 0, 0);
        check("conf_stall_clear", 32'(bus.stall_req), 0);
        check("conf_done", 32'(bus.we), 0);
        // Full / back-pressure
        step(1, 1, 1, 1, 10, 32'h10);
        step(1, 2, 2, 1, 11, 32'h11);
        step(1, 3, 3, 1, 12, 32'h12);
        check("full_ready", 32'(bus.b_ready), 0);
        check("full_cnt", 32'(bus.buf_count), 2);
        step(0, 0, 0, 1, 12, 32'h12);
        check("full_pop_ready", 32'(bus.b_ready), 0);
        check("full_pop10", 32'(bus.waddr), 10);
        step(0, 0, 0, 1, 12, 32'h12);
        check("full_accept_ready", 32'(bus.b_ready), 1);
        check("full_pop11", 32'(bus.waddr), 11);
        step(0, 0, 0, 0, 0, 0);
        check("full_pop12", 32'(bus.waddr), 12);
        check("full_pop12_data", bus.wdata, 32'h12);
        step(0, 0, 0, 0, 0, 0);
        check("full_drained", 32'(bus.buf_count), 0);
        // Hazard flags and r0 drop
        step(1, 4, 4, 1, 9, 32'h99);
        #1 bus.qaddr1 = 9; bus.qaddr2 = 0;
        step(1, 5, 5, 1, 0, 32'hBAD);
        check("haz_hit1", 32'(bus.qhit1), 1);
        check("haz_hit2", 32'(bus.qhit2), 0);
        check("haz_r0_ready", 32'(bus.b_ready), 1);
        #1 bus.qaddr2 = 9;
        step(0, 0, 0, 0, 0, 0);
        check("haz_r0_dropped", 32'(bus.buf_count), 1);
        check("haz_pop9", 32'(bus.waddr), 9);
        check("haz_hit2_9", 32'(bus.qhit2), 1);
        step(0, 0, 0, 0, 0, 0);
        check("haz_no_r0_write", 32'(bus.we), 0);
        check("haz_clear", 32'(bus.qhit1), 0);
        #1 bus.qaddr1 = 0; bus.qaddr2 = 0;
        // Reset mid-operation with two entries buffered
        step(1, 1, 1, 1, 20, 32'h20);
        step(1, 2, 2, 1, 21, 32'h21);
        step(1, 3, 3, 0, 0, 0);
        check("rst_pre_cnt", 32'(bus.buf_count), 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_we", 32'(bus.we), 0);
        check("rst_waddr", 32'(bus.waddr), 0);
        check("rst_cnt", 32'(bus.buf_count), 0);
        check("rst_ready", 32'(bus.b_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0; bus.a_we = 0;
        @(negedge clk);
        check("rst_post_ready", 32'(bus.b_ready), 1);
        check("rst_post_we", 32'(bus.we), 0);
        check("rst_post_cnt", 32'(bus.buf_count), 0);
`ifdef REGARB_STATS_EN
        step(0, 0, 0, 1, 3, 32'h3);
        step(1, 1, 1, 0, 0, 0);
        step(1, 2, 2, 0, 0, 0);
        step(1, 3, 3, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("stats_conflict3", conflict_cnt, 32'd3);
`endif
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
- Source A is the in-order pipeline writeback. It always has priority and is never back-pressured.
- Source B is the long-latency unit (divider / multicycle load) using a valid/ready handshake, buffered in a small FIFO.
- Sits between the writeback stage and the register file; provides pending-write hazard flags to decode and a stall request to the pipeline when B is starved.

Parameters:
- DEPTH, 2, B-side buffer entries (power of two, ≥2)
- MAX_WAIT, 4, consecutive cycles a buffered B head may be blocked by A before stall_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high (`RstEnable)
- a_we  in  1  pipeline writeback enable
- a_waddr  in  `RegAddrBus  pipeline writeback address
- a_wdata  in  `RegBus  pipeline writeback data
- b_valid  in  1  long-latency result valid
- b_ready  out  1  buffer can accept
- b_waddr  in  `RegAddrBus  long-latency destination
- b_wdata  in  `RegBus  long-latency result
- we  out  1  to register file write enable
- waddr  out  `RegAddrBus  to register file write address
- wdata  out  `RegBus  to register file write data
- qaddr1  in  `RegAddrBus  decode read address 1
- qaddr2  in  `RegAddrBus  decode read address 2
- qhit1  out  1  buffered B write pending to qaddr1
- qhit2  out  1  buffered B write pending to qaddr2
- stall_req  out  1  request pipeline to free the write slot
- buf_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst high): FIFO pointers, count, wait counter and stall_req cleared. While rst is high: we=0, waddr=0, wdata=0, b_ready=0, qhit*=0.
- Accept: B handshake completes when b_valid && b_ready. b_ready = !full, with no same-cycle pop-through. An accepted entry with b_waddr==0 is dropped (not stored; count unchanged).
- Port mux (combinational, zero latency):
  - If a_we: we=1, waddr=a_waddr, wdata=a_wdata.
  - Else if FIFO non-empty: the head drives the port, we=1, and the head pops at the clock edge.
  - Else: we=0, and waddr/wdata=0.
- B latency is a minimum of 1 cycle from handshake to write; there is no bypass from b_* to the port.
- Simultaneous push and pop: both occur and count is unchanged. Full FIFO with a pop: b_ready stays 0 that cycle.
- FIFO pointers wrap modulo DEPTH. Ordering is strictly FIFO among B entries.
- Wait counter:
  - Increments when the FIFO is non-empty and a_we=1; saturates at MAX_WAIT.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is registered: 1 the cycle after the counter reaches MAX_WAIT, held until the next pop.
  - If a_we stays high while stall_req=1, A still wins. A writes are never dropped.
- Hazard: qhitN=1 iff qaddrN!=0 and any stored valid entry has waddr==qaddrN. The in-flight b_* handshake is excluded; the decoder qualifies that itself.
- A-vs-B same-address ordering is prevented by the hazard flags upstream. The arbiter itself does not reorder.
- Reset mid-operation: all buffered entries are discarded.

Optional Feature:
- REGARB_STATS_EN defined:
  - Adds output conflict_cnt (32-bit): increments each cycle a_we=1 with the FIFO non-empty; wraps at 2^32; cleared on reset.
  - Adds output stall_cnt (32-bit): increments each cycle stall_req=1; wraps at 2^32; cleared on reset.
- Undefined: the ports and logic are absent.

Decomposition:
- Widths `RegBus, `RegAddrBus and `RstEnable / `WriteEnable / `ZeroWord come from defines.v.
- Add `RegArbDepth and `RegArbMaxWait defaults there.
- One sub-module: regarb_fifo. It is a parameterised synchronous FIFO holding {waddr,wdata}, with an async reset. It exposes full, empty, count, head, and per-entry addr/valid vectors for the hazard compare.

Test Plan:
- Reset: assert rst mid-cycle with 2 entries buffered → we=0 immediately, buf_count=0, b_ready=0. After release, b_ready=1.
- B only: push (b_waddr=5, 0xDEADBEEF) with a_we=0 → the next cycle shows we=1, waddr=5, wdata=0xDEADBEEF, then buf_count=0.
- Conflict: push B (r7), then hold a_we=1 for 6 cycles → A writes each cycle, stall_req=1 from cycle 5. Drop a_we → the r7 write issues and stall_req clears the following cycle.
- Full/back-pressure: push 2 entries under a_we=1 → b_ready=0. A third b_valid is held and not lost; it is accepted after the first pop.
- Hazard: buffered entry r9; qaddr1=9, qaddr2=0 → qhit1=1, qhit2=0. A b_waddr=0 push → accepted, not stored, no write issued.
- REGARB_STATS_EN: 3 conflict cycles → conflict_cnt=3.
